// File: rtl/mips_mem_sequencer.sv
// Multicycle fetch/decode/data/commit sequencer sharing one memory bus between
// instruction fetch and load/store traffic, with a sticky bus-timeout halt.
module mips_mem_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] inst_o,
  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        stall_o,
  output logic [31:0] retire_cnt_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_DATA,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_wait;
  logic [31:0]   r_inst;
  logic [31:0]   r_rdata;
  logic [31:0]   r_retire_cnt;
  logic          r_err;
  logic          r_dwe;
  logic [31:0]   r_daddr;
  logic [31:0]   r_dwdata;

  logic w_fetch;
  logic w_data;
  logic w_timeout;

  assign w_fetch   = (r_state == S_FETCH);
  assign w_data    = (r_state == S_DATA);
  // Last permitted wait cycle: an ack here is still taken, silence means halt.
  assign w_timeout = (TIMEOUT != 0) && (r_wait == WAIT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_FETCH;
      r_wait       <= '0;
      r_inst       <= '0;
      r_rdata      <= '0;
      r_retire_cnt <= '0;
      r_err        <= 1'b0;
      r_dwe        <= 1'b0;
      r_daddr      <= '0;
      r_dwdata     <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus_ack_i) begin
            r_inst  <= bus_rdata_i;
            r_wait  <= '0;
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_wait  <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          r_dwe    <= dmem_we_i;
          r_daddr  <= dmem_addr_i;
          r_dwdata <= dmem_wdata_i;
          r_wait   <= '0;
          r_state  <= dmem_req_i ? S_DATA : S_COMMIT;
        end
        S_DATA: begin
          if (bus_ack_i) begin
            if (!r_dwe) r_rdata <= bus_rdata_i;
            r_wait  <= '0;
            r_state <= S_COMMIT;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_wait  <= r_wait + 1'b1;
          end
        end
        S_COMMIT: begin
          r_retire_cnt <= r_retire_cnt + 32'd1;
          r_wait       <= '0;
          r_state      <= S_FETCH;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Bus drive is killed while reset is asserted so an abandoned request never lingers.
  assign bus_req_o    = ~rst_i & (w_fetch | w_data);
  assign bus_we_o     = ~rst_i & w_data & r_dwe;
  assign bus_addr_o   = rst_i ? 32'd0 : (w_fetch ? imem_addr_i : r_daddr);
  assign bus_wdata_o  = rst_i ? 32'd0 : r_dwdata;
  assign stall_o      = rst_i | (r_state != S_COMMIT);
  assign inst_o       = r_inst;
  assign dmem_rdata_o = r_rdata;
  assign retire_cnt_o = r_retire_cnt;
  assign err_o        = r_err;

endmodule
